// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access opcodes, FSM states and
// small decode helpers used by both the decoder side and the access unit.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int unsigned WORD_W = 32;

  function automatic logic is_store(input op_e op);
    logic res;
    res = 1'b0;
    case (op)
      OP_SW, OP_SH, OP_SB: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  // Halfword accesses need an even address, word accesses a multiple of four.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] offset);
    logic res;
    res = 1'b0;
    case (op)
      OP_LW, OP_SW:         res = (offset != 2'b00);
      OP_LH, OP_LHU, OP_SH: res = offset[0];
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_ext.sv
// Lane steering for sub-word accesses: load lane select with sign/zero
// extension, and byte/half merge into a previously read word for stores.
module mem_lane_ext
  import mem_access_unit_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = rd_word[7:0];
    case (offset)
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      2'd3:    lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h = offset[1] ? rd_word[31:16] : rd_word[15:0];

    case (op)
      OP_LB:   load_data = 32'(lane_b);
      OP_LBU:  load_data = {24'd0, lane_b};
      OP_LH:   load_data = 32'(lane_h);
      OP_LHU:  load_data = {16'd0, lane_h};
      default: load_data = rd_word;
    endcase
  end

  // Full-word stores bypass the merge and write the store data directly.
  always_comb begin
    store_word = base_word;
    case (op)
      OP_SB: begin
        case (offset)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      OP_SH: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core and a single-port data memory with a
// combinational read path; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Rdata,
  output logic        AlignErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemDin,
  output logic        MemWe,
  input  logic [31:0] MemDout
);

  state_e      state;
  op_e         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] load_data;
  logic [31:0] store_word;
  op_e         op_in;

  assign op_in = op_e'(Op);

  mem_lane_ext u_lane (
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .rd_word    (MemDout),
    .base_word  (word_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state    <= ST_IDLE;
      op_q     <= OP_LW;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      Done     <= 1'b0;
      Rdata    <= '0;
      AlignErr <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Req) begin
            op_q    <= op_in;
            addr_q  <= Addr;
            wdata_q <= Wdata;
            // Misaligned requests never touch memory; they complete next cycle.
            if (is_misaligned(op_in, Addr[1:0])) begin
              Done     <= 1'b1;
              AlignErr <= 1'b1;
              Rdata    <= '0;
            end else if (op_in == OP_SW) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (is_store(op_q)) begin
            word_q <= MemDout;
            state  <= ST_WR;
          end else begin
            Rdata    <= load_data;
            AlignErr <= 1'b0;
            Done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_WR: begin
          Rdata    <= '0;
          AlignErr <= 1'b0;
          Done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs are decoded straight from the state register so a
  // reset drops them in the same cycle the FSM returns to idle.
  assign Busy    = (state != ST_IDLE);
  assign MemWe   = (state == ST_WR);
  assign MemAddr = (state != ST_IDLE) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign MemDin  = (state == ST_WR) ? store_word : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal
// expectations plus a randomized run compared cycle by cycle to a model.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        Clk = 1'b0;
  logic        Clrn, Req;
  logic [2:0]  Op;
  logic [31:0] Addr, Wdata;
  logic        Busy, Done, AlignErr, MemWe;
  logic [31:0] Rdata, MemAddr, MemDin, MemDout;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .Clk(Clk), .Clrn(Clrn), .Req(Req), .Op(Op), .Addr(Addr), .Wdata(Wdata),
    .Busy(Busy), .Done(Done), .Rdata(Rdata), .AlignErr(AlignErr),
    .MemAddr(MemAddr), .MemDin(MemDin), .MemWe(MemWe), .MemDout(MemDout)
  );

  always #5 Clk = ~Clk;

  // Data memory: 16 words, combinational read, write on the clock edge.
  logic [31:0] mem [16];
  logic        mem_clear;
  always @(posedge Clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else if (MemWe === 1'b1) begin
      mem[MemAddr[5:2]] <= MemDin;
    end
  end
  assign MemDout = mem[MemAddr[5:2]];

  int          we_count = 0;
  logic [31:0] last_din = 32'd0;
  always @(posedge Clk) begin
    if (MemWe === 1'b1) begin
      we_count++;
      last_din = MemDin;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [31:0] sh, b, h, r;
    sh = w >> (8 * off);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (op)
      LB:      r = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      LBU:     r = b;
      LH:      r = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      LHU:     r = h;
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_val(input logic [2:0] op, input logic [31:0] w,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] m, r;
    case (op)
      SW: r = wd;
      SB: begin m = 32'hFF << (8 * off);   r = (w & ~m) | ((wd & 32'hFF) << (8 * off)); end
      SH: begin m = 32'hFFFF << (8 * off); r = (w & ~m) | ((wd & 32'hFFFF) << (8 * off)); end
      default: r = w;
    endcase
    return r;
  endfunction

  logic [31:0] ref_mem [16];
  bit          m_active = 0, m_store = 0, m_mis = 0;
  int          m_k = 0, m_lat = 0;
  logic [3:0]  m_idx = '0;
  logic [31:0] m_res = '0, m_new = '0, m_waddr = '0;
  logic        e_done = 0, e_busy = 0, e_we = 0, e_align = 0;
  logic [31:0] e_addr = '0, e_din = '0, e_rdata = '0;

  always @(posedge Clk) begin
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] w;
    if (mem_clear) for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    if (e_we) ref_mem[m_idx] = m_new;
    if (Clrn !== 1'b1) begin
      m_active = 0;
      e_rdata  = 32'd0;
      e_align  = 1'b0;
    end else if (!m_active || m_k == m_lat) begin
      if (Req === 1'b1) begin
        op       = Op;
        off      = Addr[1:0];
        m_idx    = Addr[5:2];
        m_waddr  = {Addr[31:2], 2'b00};
        w        = ref_mem[m_idx];
        m_store  = (op >= SW);
        m_mis    = ((op == LW || op == SW) && off != 2'b00) ||
                   ((op == LH || op == LHU || op == SH) && off[0]);
        m_lat    = m_mis ? 1 : (op == SB || op == SH) ? 3 : 2;
        m_res    = (m_mis || m_store) ? 32'd0 : load_val(op, w, off);
        m_new    = store_val(op, w, off, Wdata);
        m_active = 1;
        m_k      = 1;
      end else begin
        m_active = 0;
      end
    end else begin
      m_k++;
    end
    e_done = m_active && (m_k == m_lat);
    if (e_done) begin
      e_rdata = m_res;
      e_align = m_mis;
    end
    e_busy = m_active && (m_k < m_lat);
    e_we   = m_active && m_store && !m_mis && (m_k == m_lat - 1);
    e_addr = e_busy ? m_waddr : 32'd0;
    e_din  = m_new;
  end

  bit chk_en = 0;
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("Done", {31'd0, Done}, {31'd0, e_done});
      chk("Busy", {31'd0, Busy}, {31'd0, e_busy});
      chk("MemWe", {31'd0, MemWe}, {31'd0, e_we});
      chk("MemAddr", MemAddr, e_addr);
      if (e_we) chk("MemDin", MemDin, e_din);
      chk("Rdata", Rdata, e_rdata);
      chk("AlignErr", {31'd0, AlignErr}, {31'd0, e_align});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                     output int lat);
    Op = op; Addr = a; Wdata = wd; Req = 1'b1;
    @(posedge Clk); #1;
    Req = 1'b0;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (Done !== 1'b1 && lat < 12);
    @(posedge Clk); #1;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_al);
    int lat;
    run(op, a, wd, lat);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_rdata"}, Rdata, exp_rd);
    chk({name, "_alignerr"}, {31'd0, AlignErr}, {31'd0, exp_al});
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int w0, n, d1, d2;
    Clrn = 1'b0; Req = 1'b0; Op = LW; Addr = '0; Wdata = '0; mem_clear = 1'b1;
    repeat (3) @(posedge Clk);
    #1 mem_clear = 1'b0;
    @(negedge Clk);
    chk("rst_Done", {31'd0, Done}, 32'd0);
    chk("rst_Busy", {31'd0, Busy}, 32'd0);
    chk("rst_MemWe", {31'd0, MemWe}, 32'd0);
    chk("rst_MemAddr", MemAddr, 32'd0);
    chk("rst_Rdata", Rdata, 32'd0);
    @(posedge Clk); #1;
    Clrn = 1'b1;
    chk_en = 1;

    // Sign and zero extension of the top byte.
    check_op("pre_w0", SW, 32'h0, 32'h80FF7F01, 2, 32'h0, 1'b0);
    check_op("lb3", LB, 32'h3, 32'h0, 2, 32'hFFFFFF80, 1'b0);
    check_op("lbu3", LBU, 32'h3, 32'h0, 2, 32'h00000080, 1'b0);

    // Byte read-modify-write.
    check_op("pre_w4", SW, 32'h4, 32'h11223344, 2, 32'h0, 1'b0);
    w0 = we_count;
    check_op("sb5", SB, 32'h5, 32'h000000AB, 3, 32'h0, 1'b0);
    chk("sb5_we_pulses", we_count - w0, 1);
    chk("sb5_memdin", last_din, 32'h1122AB44);
    check_op("lw4", LW, 32'h4, 32'h0, 2, 32'h1122AB44, 1'b0);

    // Misaligned accesses.
    check_op("pre_w8", SW, 32'h8, 32'h5555AAAA, 2, 32'h0, 1'b0);
    w0 = we_count;
    check_op("lw6_mis", LW, 32'h6, 32'h0, 1, 32'h0, 1'b1);
    check_op("sh9_mis", SH, 32'h9, 32'h1234, 1, 32'h0, 1'b1);
    chk("mis_we_pulses", we_count - w0, 0);
    check_op("lw8_after_mis", LW, 32'h8, 32'h0, 2, 32'h5555AAAA, 1'b0);

    // Back-to-back: LH requested in the Done cycle of a SW.
    Op = SW; Addr = 32'h8; Wdata = 32'hDEADBEEF; Req = 1'b1;
    @(posedge Clk); #1 Req = 1'b0;
    @(posedge Clk); #1;
    Op = LH; Addr = 32'hA; Wdata = 32'h0; Req = 1'b1;
    @(negedge Clk);
    chk("b2b_sw_done", {31'd0, Done}, 32'd1);
    @(posedge Clk); #1 Req = 1'b0;
    @(negedge Clk);
    chk("b2b_lh_busy", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    chk("b2b_lh_done", {31'd0, Done}, 32'd1);
    chk("b2b_lh_rdata", Rdata, 32'hFFFFDEAD);
    @(posedge Clk); #1;

    // Reset while a halfword store is in its read phase.
    check_op("pre_wc", SW, 32'hC, 32'hCAFEF00D, 2, 32'h0, 1'b0);
    check_op("lwc", LW, 32'hC, 32'h0, 2, 32'hCAFEF00D, 1'b0);
    w0 = we_count;
    Op = SH; Addr = 32'hE; Wdata = 32'h1234; Req = 1'b1;
    @(posedge Clk); #1;
    Req = 1'b0; Clrn = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rstmid_Done", {31'd0, Done}, 32'd0);
    chk("rstmid_Busy", {31'd0, Busy}, 32'd0);
    chk("rstmid_MemWe", {31'd0, MemWe}, 32'd0);
    chk("rstmid_MemAddr", MemAddr, 32'd0);
    chk("rstmid_MemDin", MemDin, 32'd0);
    chk("rstmid_Rdata", Rdata, 32'd0);
    chk("rstmid_AlignErr", {31'd0, AlignErr}, 32'd0);
    @(posedge Clk); #1 Clrn = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rstmid_we_pulses", we_count - w0, 0);
    check_op("lwc_after_rst", LW, 32'hC, 32'h0, 2, 32'hCAFEF00D, 1'b0);

    // Req held high across SB: second access accepted only after the first completes.
    Op = SB; Addr = 32'h5; Wdata = 32'h77; Req = 1'b1;
    @(posedge Clk); #1;
    n = 0; d1 = 0; d2 = 0;
    while (n < 8) begin
      @(negedge Clk);
      n++;
      if (Done === 1'b1) begin
        if (d1 == 0) d1 = n; else if (d2 == 0) d2 = n;
      end
      if (n == 6) Req = 1'b0;
    end
    chk("held_first_done", d1, 3);
    chk("held_second_done", d2, 6);
    @(posedge Clk); #1;
    check_op("lw4_after_held", LW, 32'h4, 32'h0, 2, 32'h11227744, 1'b0);

    // Randomized traffic, including stray resets and requests while busy.
    for (int c = 0; c < 800; c++) begin
      logic [31:0] a;
      logic [2:0]  op;
      op = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (op == LW || op == SW) a = a & 32'hFFFFFFFC;
        else if (op == LH || op == LHU || op == SH) a = a & 32'hFFFFFFFE;
      end
      Clrn  = ($urandom_range(0, 49) != 0);
      Req   = ($urandom_range(0, 2) != 0);
      Op    = op;
      Addr  = a;
      Wdata = $urandom;
      @(posedge Clk); #1;
    end
    Req = 1'b0; Clrn = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
